// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction layout, memory geometry and loader states.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 24;

  // Instruction fields: {op, rd, rs1, rs2, imm}
  localparam int unsigned OP_HI  = 23;
  localparam int unsigned OP_LO  = 20;
  localparam int unsigned RD_HI  = 19;
  localparam int unsigned RD_LO  = 16;
  localparam int unsigned RS1_HI = 15;
  localparam int unsigned RS1_LO = 12;
  localparam int unsigned RS2_HI = 11;
  localparam int unsigned RS2_LO = 8;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  localparam int unsigned BYTES_PER_INSTR = INSTR_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    BYTE,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects three stream bytes, MSB first, into one instruction word.
module word_assembler
  import cpu_pkg::*;
#(
  parameter int unsigned WORD_W = cpu_pkg::INSTR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned SH_W = WORD_W - 8;

  logic [SH_W-1:0] sh_q, sh_d;
  logic [1:0]      idx_q, idx_d;

  // The completed word is presented combinationally with its final byte, so
  // the caller can capture it on the same edge the byte is accepted.
  always_comb begin
    sh_d       = sh_q;
    idx_d      = idx_q;
    word_valid = byte_valid && (idx_q == 2'd2);
    word       = {sh_q, byte_in};
    if (clear) begin
      sh_d  = '0;
      idx_d = 2'd0;
    end else if (byte_valid) begin
      sh_d  = {sh_q[SH_W-9:0], byte_in};
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Shift register and byte index.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      idx_q <= 2'd0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Instruction memory loader: byte stream -> 24-bit words -> imem, with a
// trailing XOR checksum gating release of the CPU from reset.
//
// state | meaning
// IDLE  | after reset, waiting for start
// COUNT | accepting the word-count byte
// BYTE  | accepting data bytes of the current word
// WRITE | single-cycle imem write of the assembled word
// CHECK | accepting the checksum byte
// DONE  | load good, CPU released; start reloads
// ERROR | checksum bad, CPU held; start reloads
module prog_loader
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = cpu_pkg::ADDR_W,
  parameter int unsigned       INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    words_loaded
);

  // A zero count byte stands for a full memory image.
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] REM_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_e        state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W:0]      rem_q, rem_d;
  logic [ADDR_W:0]      words_q, words_d;
  logic [7:0]           ck_q, ck_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 hold_q, hold_d;

  logic                 asm_clear;
  logic                 asm_push;
  logic                 word_valid;
  logic [INSTR_W-1:0]   word;

  assign asm_push = (state_q == BYTE) && in_valid;

  word_assembler #(.WORD_W(INSTR_W)) u_asm (
    .CLK        (CLK),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_push),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rem_d     = rem_q;
    words_d   = words_q;
    ck_d      = ck_q;
    done_d    = done_q;
    error_d   = error_q;
    hold_d    = hold_q;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    asm_clear = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = COUNT;
          done_d    = 1'b0;
          error_d   = 1'b0;
          words_d   = '0;
          ck_d      = '0;
          addr_d    = BASE_ADDR;
          hold_d    = 1'b1;
          asm_clear = 1'b1;
        end
      end
      COUNT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rem_d   = (in_data == 8'd0) ? FULL_COUNT
                                      : {{(ADDR_W-7){1'b0}}, in_data};
          ck_d    = ck_q ^ in_data;
          state_d = BYTE;
        end
      end
      BYTE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ck_d = ck_q ^ in_data;
          if (word_valid) begin
            wdata_d = word;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        imem_we = 1'b1;
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == REM_ONE) ? CHECK : BYTE;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == ck_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = DONE;
          end else begin
            error_d = 1'b1;
            state_d = ERROR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset keeps the CPU held.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      rem_q   <= '0;
      words_q <= '0;
      ck_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      ck_q    <= ck_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued from the
// stream contents, a monitor pops them as imem_we pulses appear.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [23:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [23:0] wq[$];
  logic        prev_we = 1'b0;
  logic [31:0] mon_e;

  always #5 clk = ~clk;

  prog_loader dut (
    .CLK          (clk),
    .reset        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (imem_we) begin
      chk("we_not_adjacent", 32'(prev_we), 0);
      chk("no_accept_in_write", 32'(in_ready), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(mon_e[31:24]));
        chk("write_data", 32'(imem_wdata), 32'(mon_e[23:0]));
      end
    end
    prev_we <= imem_we;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_imem_wdata", 32'(imem_wdata), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_words", 32'(words_loaded), 0);
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Offer one byte, with random idle gaps first; returns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int g;
    bit fired;
    g = 0;
    fired = 1'b0;
    while (g < 8 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
      g++;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 40 && !fired; t++) begin
      @(negedge clk);
      fired = in_ready;
      tick();
    end
    if (!fired) chk("accept_timeout", 0, 1);
  endtask

  // Full load of the words in wq; cnt==0 means 256 words.
  task automatic run_load(input int cnt, input bit bad, input int gap_pct, input int start_at);
    logic [7:0]  s[$];
    logic [7:0]  ck;
    logic [23:0] w;
    int          n;
    bit          fin;
    n  = (cnt == 0) ? 256 : cnt;
    ck = 8'(cnt);
    s.push_back(8'(cnt));
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      exp_q.push_back({8'(i), w});
      for (int j = 2; j >= 0; j--) begin
        s.push_back(w[j*8 +: 8]);
        ck ^= w[j*8 +: 8];
      end
    end
    s.push_back(bad ? (ck ^ 8'h01) : ck);

    pulse_start();
    @(negedge clk);
    chk("start_count_ready", 32'(in_ready), 1);
    chk("start_clr_done", 32'(done), 0);
    chk("start_clr_error", 32'(error), 0);
    chk("start_hold", 32'(cpu_hold), 1);
    chk("start_clr_words", 32'(words_loaded), 0);
    tick();

    for (int k = 0; k < s.size(); k++) begin
      if (k == start_at) pulse_start();
      send_byte(s[k], gap_pct);
      if (k >= 3 && k <= 3 * n && (k % 3) == 0) begin
        @(negedge clk);
        chk("we_latency", 32'(imem_we), 1);
        tick();
      end
    end
    in_valid = 1'b0;

    fin = 1'b0;
    for (int t = 0; t < 20 && !fin; t++) begin
      @(negedge clk);
      fin = done | error;
    end
    if (!fin) chk("finish_timeout", 0, 1);
    chk("end_done", 32'(done), bad ? 0 : 1);
    chk("end_error", 32'(error), bad ? 1 : 0);
    chk("end_hold", 32'(cpu_hold), bad ? 1 : 0);
    chk("end_words", 32'(words_loaded), n);
    chk("all_writes_seen", exp_q.size(), 0);
    tick();
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(24'($urandom));
  endtask

  initial begin
    int c;
    #1 rst_n = 1'b0;
    #22;
    check_reset_vals();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h05;
    tick();
    @(negedge clk);
    chk("idle_not_ready", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0;

    // Basic, bad checksum, then backpressure on the same image.
    wq.delete();
    wq.push_back(24'h123456);
    wq.push_back(24'hABCDEF);
    run_load(2, 1'b0, 0, -1);
    run_load(2, 1'b1, 0, -1);
    run_load(2, 1'b0, 40, -1);

    for (int r = 0; r < 4; r++) begin
      c = int'($urandom_range(1, 8));
      fill_random(c);
      run_load(c, 1'b0, int'($urandom_range(0, 50)), -1);
    end

    fill_random(256);
    run_load(0, 1'b0, 0, -1);

    // Start pulse in the middle of the data bytes must be ignored.
    fill_random(3);
    run_load(3, 1'b0, 20, 4);

    // Reset after the second byte of word 1: word 0 lands, word 1 must not.
    exp_q.push_back({8'h00, 24'h123456});
    pulse_start();
    tick();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("reset_no_partial", exp_q.size(), 0);
    chk("reset_hold", 32'(cpu_hold), 1);

    wq.delete();
    wq.push_back(24'h123456);
    wq.push_back(24'hABCDEF);
    run_load(2, 1'b0, 10, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
